// File: rtl/version_pkg.sv
// Build identification constants. The build flow regenerates this file with
// the real version and timestamp of each bitstream.
package version_pkg;
  localparam logic [7:0]  MAJOR  = 8'h01;
  localparam logic [7:0]  MINOR  = 8'h02;
  localparam logic [7:0]  PATCH  = 8'h03;
  localparam logic [7:0]  BUILD  = 8'h04;
  localparam logic [15:0] YEAR   = 16'h2026;
  localparam logic [7:0]  MONTH  = 8'h01;
  localparam logic [7:0]  DAY    = 8'h14;
  localparam logic [7:0]  HOUR   = 8'h11;
  localparam logic [7:0]  MINUTE = 8'h20;
  localparam logic [7:0]  SECOND = 8'h43;
endpackage

// File: rtl/version_reporter.sv
// version_reporter
// Streams a 13-byte identification frame on a valid/ready byte interface:
// sync byte, 11 payload bytes (version + timestamp) and a checksum byte.
//
// Ports:
//   clk        sole clock
//   rst        asynchronous active-high reset; aborts any frame in progress
//   req        frame request, sampled every clk edge
//   out_valid  out_data holds a frame byte
//   out_ready  downstream accepts the byte when out_valid && out_ready
//   out_data   frame byte
//   out_last   high with the checksum byte
//   busy       frame in progress or a request pending
//
// Build option: VERSION_REPORTER_CRC8_EN replaces the XOR checksum with a
// CRC-8 (poly 0x07, init 0x00, MSB-first, no reflection, no final XOR).
//
// state | meaning
// IDLE  | nothing presented, waiting for req
// SEND  | presenting frame byte r_idx (0..12)
module version_reporter #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter logic [87:0] VERSION_FIELDS = {version_pkg::MAJOR, version_pkg::MINOR,
                                           version_pkg::PATCH, version_pkg::BUILD,
                                           version_pkg::YEAR,  version_pkg::MONTH,
                                           version_pkg::DAY,   version_pkg::HOUR,
                                           version_pkg::MINUTE, version_pkg::SECOND}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       busy
);

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t     r_state;
  logic [3:0] r_idx;
  logic [7:0] r_csum;
  logic       r_pending;

  logic       w_hs;
  logic [3:0] w_idx_nxt;
  logic [7:0] w_cur_field;
  logic [7:0] w_nxt_field;
  logic [7:0] w_csum_upd;

  // Payload byte for frame index 1..11; zero elsewhere.
  function automatic logic [7:0] field_byte(input logic [3:0] idx);
    logic [7:0] b;
    b = 8'h00;
    for (int k = 1; k <= 11; k++) begin
      if (idx == k[3:0]) b = VERSION_FIELDS[87 - 8*(k-1) -: 8];
    end
    return b;
  endfunction

  function automatic logic [7:0] csum_step(input logic [7:0] acc, input logic [7:0] b);
`ifdef VERSION_REPORTER_CRC8_EN
    logic [7:0] c;
    c = acc ^ b;
    for (int k = 0; k < 8; k++) begin
      c = c[7] ? ((c << 1) ^ 8'h07) : (c << 1);
    end
    return c;
`else
    return acc ^ b;
`endif
  endfunction

  assign w_hs        = out_valid & out_ready;
  assign w_idx_nxt   = r_idx + 4'd1;
  assign w_cur_field = field_byte(r_idx);
  assign w_nxt_field = field_byte(w_idx_nxt);
  assign w_csum_upd  = csum_step(r_csum, w_cur_field);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_idx     <= 4'd0;
      r_csum    <= 8'h00;
      r_pending <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= 8'h00;
      out_last  <= 1'b0;
      busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req) begin
            r_state   <= ST_SEND;
            r_idx     <= 4'd0;
            r_csum    <= 8'h00;
            out_valid <= 1'b1;
            out_data  <= SYNC_BYTE;
            out_last  <= 1'b0;
            busy      <= 1'b1;
          end
        end
        ST_SEND: begin
          if (w_hs && r_idx == 4'd12) begin
            // A request arriving on the final handshake is honoured directly,
            // so the follow-on frame starts without an idle cycle.
            r_pending <= 1'b0;
            r_idx     <= 4'd0;
            r_csum    <= 8'h00;
            out_last  <= 1'b0;
            if (r_pending || req) begin
              out_valid <= 1'b1;
              out_data  <= SYNC_BYTE;
              busy      <= 1'b1;
            end else begin
              r_state   <= ST_IDLE;
              out_valid <= 1'b0;
              out_data  <= 8'h00;
              busy      <= 1'b0;
            end
          end else begin
            if (req) r_pending <= 1'b1;
            if (w_hs) begin
              r_idx <= w_idx_nxt;
              // The sync byte (index 0) never enters the checksum.
              if (r_idx != 4'd0) r_csum <= w_csum_upd;
              out_data <= (w_idx_nxt == 4'd12) ? w_csum_upd : w_nxt_field;
              out_last <= (w_idx_nxt == 4'd12);
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_version_reporter.sv
module tb_version_reporter;

`ifdef VERSION_REPORTER_CRC8_EN
  localparam logic [87:0] FIELDS = {"12345678", 24'h393939};
`else
  localparam logic [87:0] FIELDS = {8'h01, 8'h02, 8'h03, 8'h04, 16'h2026, 8'h01,
                                    8'h14, 8'h11, 8'h20, 8'h43};
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_last;
  logic       busy;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_frame [13];

  version_reporter #(.SYNC_BYTE(8'hA5), .VERSION_FIELDS(FIELDS)) dut (
    .clk(clk), .rst(rst), .req(req), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_last(out_last), .busy(busy));

  always #5 clk = ~clk;

  // Reference checksum over the 88-bit payload treated as one message.
  function automatic logic [7:0] model_check(input logic [87:0] f);
    logic [7:0] r;
    r = 8'h00;
`ifdef VERSION_REPORTER_CRC8_EN
    // Long division of the whole 88-bit message by x^8+x^2+x+1.
    for (int i = 87; i >= 0; i--) begin
      logic fb;
      fb = r[7] ^ f[i];
      r  = {r[6:0], 1'b0};
      if (fb) r = r ^ 8'h07;
    end
`else
    for (int i = 0; i < 11; i++) r = r ^ f[8*i +: 8];
`endif
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; req = 1'b0; out_ready = 1'b0;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
    checks++; if (out_data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", out_data); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last: got %b expected 0", out_last); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    out_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_frame[i] || out_last !== (i == 12) || busy !== 1'b1) begin
        errors++;
        $display("FAIL single_byte%0d: got v=%b d=%h l=%b b=%b expected v=1 d=%h l=%b b=1",
                 i, out_valid, out_data, out_last, busy, exp_frame[i], (i == 12));
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_end: got v=%b b=%b expected v=0 b=0", out_valid, busy);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] got [$];
    logic       prev_stall;
    logic [7:0] pd;
    logic       pl;
    prev_stall = 1'b0; pd = 8'h00; pl = 1'b0;
    req = 1'b1; out_ready = 1'($urandom_range(0, 1));
    tick();
    req = 1'b0;
    for (int cyc = 0; cyc < 600 && got.size() < 13; cyc++) begin
      out_ready = 1'($urandom_range(0, 1));
      if (prev_stall) begin
        checks++;
        if (out_valid !== 1'b1 || out_data !== pd || out_last !== pl) begin
          errors++;
          $display("FAIL bp_stall_hold: got v=%b d=%h l=%b expected v=1 d=%h l=%b",
                   out_valid, out_data, out_last, pd, pl);
        end
      end
      if (out_valid && out_ready) got.push_back(out_data);
      prev_stall = out_valid && !out_ready;
      pd = out_data; pl = out_last;
      tick();
    end
    out_ready = 1'b1;
    checks++;
    if (got.size() != 13) begin
      errors++; $display("FAIL bp_count: got %0d bytes expected 13", got.size());
    end else begin
      for (int i = 0; i < 13; i++) begin
        checks++;
        if (got[i] !== exp_frame[i]) begin
          errors++; $display("FAIL bp_byte%0d: got %h expected %h", i, got[i], exp_frame[i]);
        end
      end
    end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_end_valid: got %b expected 0", out_valid); end
  endtask

  // Cycle c=0 issues the first req; frame bytes appear at c=1..13 and the
  // second frame must occupy c=14..26 with nothing after.
  task automatic test_three_req();
    int p0, p1, p2;
    p0 = $urandom_range(2, 4); p1 = $urandom_range(5, 8); p2 = $urandom_range(9, 12);
    out_ready = 1'b1;
    for (int c = 0; c < 36; c++) begin
      logic ev;
      req = (c == 0 || c == p0 || c == p1 || c == p2);
      ev = (c >= 1 && c <= 26);
      checks++;
      if (out_valid !== ev || (ev && (out_data !== exp_frame[(c-1)%13] || out_last !== ((c-1)%13 == 12)))) begin
        errors++;
        $display("FAIL three_req_c%0d: got v=%b d=%h l=%b expected v=%b d=%h l=%b", c,
                 out_valid, out_data, out_last, ev, exp_frame[(c+12)%13], ((c+12)%13 == 12));
      end
      tick();
    end
    req = 1'b0;
  endtask

  task automatic test_coincident();
    out_ready = 1'b1;
    for (int c = 0; c < 32; c++) begin
      logic ev;
      req = (c == 0 || c == 13);
      ev = (c >= 1 && c <= 26);
      if (c == 13) begin
        checks++;
        if (out_last !== 1'b1) begin errors++; $display("FAIL coinc_last: got %b expected 1", out_last); end
      end
      checks++;
      if (out_valid !== ev || (ev && out_data !== exp_frame[(c-1)%13])) begin
        errors++;
        $display("FAIL coinc_c%0d: got v=%b d=%h expected v=%b d=%h", c, out_valid, out_data,
                 ev, exp_frame[(c+12)%13]);
      end
      tick();
    end
    req = 1'b0;
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b1; req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks++;
    if (out_data !== exp_frame[6]) begin errors++; $display("FAIL rst_mid_pos: got %h expected %h", out_data, exp_frame[6]); end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== 8'h00 || out_last !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_async: got v=%b d=%h l=%b b=%b expected 0/00/0/0", out_valid, out_data, out_last, busy);
    end
    tick();
    rst = 1'b0;
    tick();
    req = 1'b1;
    tick();
    req = 1'b0;
    for (int i = 0; i < 13; i++) begin
      checks++;
      if (out_valid !== 1'b1 || out_data !== exp_frame[i]) begin
        errors++; $display("FAIL rst_mid_byte%0d: got v=%b d=%h expected v=1 d=%h", i, out_valid, out_data, exp_frame[i]);
      end
      tick();
    end
  endtask

  // Random req and ready: every accepted byte must follow the frame sequence.
  task automatic test_random_stream();
    int n;
    n = 0;
    for (int c = 0; c < 400; c++) begin
      req = ($urandom_range(0, 9) == 0);
      out_ready = 1'($urandom_range(0, 1));
      if (out_valid && out_ready) begin
        checks++;
        if (out_data !== exp_frame[n%13] || out_last !== (n%13 == 12)) begin
          errors++; $display("FAIL rand_byte%0d: got d=%h l=%b expected d=%h l=%b", n, out_data, out_last, exp_frame[n%13], (n%13 == 12));
        end
        n++;
      end
      tick();
    end
    req = 1'b0; out_ready = 1'b1;
    for (int c = 0; c < 40 && (out_valid || busy); c++) begin
      if (out_valid) n++;
      tick();
    end
    checks++;
    if (n % 13 != 0 || out_valid !== 1'b0) begin
      errors++; $display("FAIL rand_drain: got %0d bytes v=%b expected multiple of 13, v=0", n, out_valid);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    exp_frame[0] = 8'hA5;
    for (int i = 1; i <= 11; i++) exp_frame[i] = FIELDS[87 - 8*(i-1) -: 8];
    exp_frame[12] = model_check(FIELDS);
    test_reset();
    test_single();
    test_backpressure();
    tick();
    test_three_req();
    test_coincident();
    test_reset_mid();
    test_random_stream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
